// File: rtl/mmio_io_bridge_if.sv
// mmio_io_bridge_if: CPU data-memory bus as seen by the MMIO I/O bridge.
// The CPU side drives command/address/write data; the bridge returns a
// registered read response (read_data qualified by the rd_valid pulse).
interface mmio_io_bridge_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
);
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              rd_valid;

  modport master (
    output mem_cmd,
    output mem_addr,
    output write_data,
    input  read_data,
    input  rd_valid
  );

  modport slave (
    input  mem_cmd,
    input  mem_addr,
    input  write_data,
    output read_data,
    output rd_valid
  );
endinterface

// File: rtl/mmio_io_bridge.sv
// mmio_io_bridge: memory-mapped switch/LED/HEX register block for the
// Simple RISC Machine data-memory bus.
//   offset 0 SW_DATA  RO  debounced switches
//   offset 1 SW_EDGE  RO  sticky rising edges, write-1-to-clear
//   offset 2 LED      RW
//   offset 3 HEX      RW  nibbles decoded to active-low 7-segment glyphs
//   offset 4 IRQ_MASK RW  only when MMIO_IO_BRIDGE_IRQ_EN is defined, which
//                         also adds the registered irq output
// Reads return one cycle after the command with pre-update register state.
module mmio_io_bridge #(
  parameter int                DATA_W          = 16,
  parameter int                ADDR_W          = 9,
  parameter logic [ADDR_W-1:0] BASE            = 9'h140,
  parameter int                SW_W            = 10,
  parameter int                LED_W           = 10,
  parameter int                HEX_DIGITS      = 4,
  parameter int                DEBOUNCE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  mmio_io_bridge_if.slave         bus,
  input  logic [SW_W-1:0]         sw_in,
  output logic [LED_W-1:0]        led_out,
  output logic [7*HEX_DIGITS-1:0] hex_seg
`ifdef MMIO_IO_BRIDGE_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int HEX_W = 4 * HEX_DIGITS;
  localparam int CW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10,
    CMD_RSVD  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    REG_SW_DATA  = 3'd0,
    REG_SW_EDGE  = 3'd1,
    REG_LED      = 3'd2,
    REG_HEX      = 3'd3,
    REG_IRQ_MASK = 3'd4
  } reg_e;

  logic              hit;
  logic              rd_en;
  logic              wr_en;
  logic [2:0]        offset;

  logic [SW_W-1:0]   sync1_q;
  logic [SW_W-1:0]   sync2_q;
  logic [SW_W-1:0]   stable_q;
  logic [SW_W-1:0]   stable_d;
  logic [CW-1:0]     cnt_q [SW_W];
  logic [CW-1:0]     cnt_d [SW_W];

  logic [SW_W-1:0]   edge_q;
  logic [SW_W-1:0]   edge_d;
  logic [SW_W-1:0]   edge_clr;

  logic [LED_W-1:0]  led_q;
  logic [HEX_W-1:0]  hex_q;
  logic [DATA_W-1:0] rd_val;

`ifdef MMIO_IO_BRIDGE_IRQ_EN
  logic [SW_W-1:0]   mask_q;
`endif

  // Address window decode and command qualification.
  always_comb begin
    hit    = (bus.mem_addr[ADDR_W-1:3] == BASE[ADDR_W-1:3]);
    offset = bus.mem_addr[2:0];
    rd_en  = hit && (bus.mem_cmd == CMD_READ);
    wr_en  = hit && (bus.mem_cmd == CMD_WRITE);
  end

  // Two-flop synchroniser on the raw switch pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: count consecutive cycles the synchronised bit
  // differs from the stable bit; accept on the DEBOUNCE_CYCLES-th one.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < SW_W; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int unsigned i = 0; i < SW_W; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d;
      for (int unsigned i = 0; i < SW_W; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Sticky rising-edge capture; a rise on the clearing edge keeps the bit set.
  always_comb begin
    edge_clr = '0;
    if (wr_en && (offset == REG_SW_EDGE)) begin
      edge_clr = bus.write_data[SW_W-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
  end

  // Edge register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      edge_q <= '0;
    end else begin
      edge_q <= edge_d;
    end
  end

  // Writable registers: LED, HEX and (optionally) the IRQ mask.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      led_q  <= '0;
      hex_q  <= '0;
`ifdef MMIO_IO_BRIDGE_IRQ_EN
      mask_q <= '0;
`endif
    end else if (wr_en) begin
      case (offset)
        REG_LED:      led_q  <= bus.write_data[LED_W-1:0];
        REG_HEX:      hex_q  <= bus.write_data[HEX_W-1:0];
`ifdef MMIO_IO_BRIDGE_IRQ_EN
        REG_IRQ_MASK: mask_q <= bus.write_data[SW_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Read mux over current (pre-update) register state, zero-extended.
  always_comb begin
    rd_val = '0;
    case (offset)
      REG_SW_DATA:  rd_val[SW_W-1:0]  = stable_q;
      REG_SW_EDGE:  rd_val[SW_W-1:0]  = edge_q;
      REG_LED:      rd_val[LED_W-1:0] = led_q;
      REG_HEX:      rd_val[HEX_W-1:0] = hex_q;
`ifdef MMIO_IO_BRIDGE_IRQ_EN
      REG_IRQ_MASK: rd_val[SW_W-1:0]  = mask_q;
`endif
      default: ;
    endcase
  end

  // Registered read response; data is forced to zero when not valid.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.rd_valid  <= 1'b0;
      bus.read_data <= '0;
    end else begin
      bus.rd_valid  <= rd_en;
      bus.read_data <= rd_en ? rd_val : '0;
    end
  end

`ifdef MMIO_IO_BRIDGE_IRQ_EN
  // Interrupt follows the registered edge/mask state by one cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_q & mask_q);
    end
  end
`endif

  assign led_out = led_q;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Combinational 7-segment decode of each HEX nibble.
  always_comb begin
    hex_seg = '1;
    for (int unsigned k = 0; k < HEX_DIGITS; k++) begin
      hex_seg[7*k +: 7] = seg7(hex_q[4*k +: 4]);
    end
  end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// tb_mmio_io_bridge: directed + randomized bench for mmio_io_bridge with a
// cycle-level behavioural model compared against the DUT every cycle.
module tb_mmio_io_bridge;

  localparam int          DB   = 4;
  localparam int          SW   = 10;
  localparam logic [8:0]  BASE = 9'h140;

  logic        clk;
  logic        reset_n;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;
  logic [27:0] hex_seg;
`ifdef MMIO_IO_BRIDGE_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  mmio_io_bridge_if #(.DATA_W(16), .ADDR_W(9)) bus ();

  mmio_io_bridge #(
    .DATA_W(16), .ADDR_W(9), .BASE(BASE), .SW_W(SW), .LED_W(10),
    .HEX_DIGITS(4), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out),
    .hex_seg (hex_seg)
`ifdef MMIO_IO_BRIDGE_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] glyph [16];
  initial begin
    glyph[0]  = 7'h40; glyph[1]  = 7'h79; glyph[2]  = 7'h24; glyph[3]  = 7'h30;
    glyph[4]  = 7'h19; glyph[5]  = 7'h12; glyph[6]  = 7'h02; glyph[7]  = 7'h78;
    glyph[8]  = 7'h00; glyph[9]  = 7'h10; glyph[10] = 7'h08; glyph[11] = 7'h03;
    glyph[12] = 7'h46; glyph[13] = 7'h21; glyph[14] = 7'h06; glyph[15] = 7'h0E;
  end

  bit          started = 0;
  logic [9:0]  p1, p2;          // pin value seen 1 and 2 edges ago
  bit          hist [SW][DB];   // last DB synchronised samples, newest at 0
  logic [9:0]  m_stable, m_edge, m_led, m_mask;
  logic [15:0] m_hex;
  logic        m_rv, m_irq;
  logic [15:0] m_rd;

  function automatic logic [15:0] m_reg(input int off);
    case (off)
      0: return {6'b0, m_stable};
      1: return {6'b0, m_edge};
      2: return {6'b0, m_led};
      3: return m_hex;
`ifdef MMIO_IO_BRIDGE_IRQ_EN
      4: return {6'b0, m_mask};
`endif
      default: return 16'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model
    int         off;
    bit         hit, rd, wr, all_diff;
    logic [9:0] nst, clr;
    if (!reset_n) begin
      started = 1;
      p1 = '0; p2 = '0;
      m_stable = '0; m_edge = '0; m_led = '0; m_mask = '0; m_hex = '0;
      m_rv = 0; m_rd = '0; m_irq = 0;
      for (int c = 0; c < SW; c++) for (int k = 0; k < DB; k++) hist[c][k] = 0;
    end else if (started) begin
      hit = ((bus.mem_addr >> 3) == (BASE >> 3));
      off = int'(bus.mem_addr & 9'h7);
      rd  = hit && (bus.mem_cmd == 2'b01);
      wr  = hit && (bus.mem_cmd == 2'b10);
      m_rv  = rd;
      m_rd  = rd ? m_reg(off) : 16'h0;
      m_irq = |(m_edge & m_mask);
      // a channel flips once its last DB synchronised samples all disagree
      nst = m_stable;
      for (int c = 0; c < SW; c++) begin
        for (int k = DB - 1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0] = p2[c];
        all_diff = 1;
        for (int k = 0; k < DB; k++) if (hist[c][k] == m_stable[c]) all_diff = 0;
        if (all_diff) begin
          nst[c] = ~m_stable[c];
          for (int k = 0; k < DB; k++) hist[c][k] = nst[c];
        end
      end
      clr = (wr && off == 1) ? bus.write_data[9:0] : 10'h0;
      m_edge   = (m_edge & ~clr) | (nst & ~m_stable);
      m_stable = nst;
      p2 = p1;
      p1 = sw_in;
      if (wr && off == 2) m_led = bus.write_data[9:0];
      if (wr && off == 3) m_hex = bus.write_data;
`ifdef MMIO_IO_BRIDGE_IRQ_EN
      if (wr && off == 4) m_mask = bus.write_data[9:0];
`endif
    end
  end

  // Per-cycle compare of every DUT output against the model.
  initial begin : compare
    logic [27:0] exp_hex;
    forever begin
      @(posedge clk);
      #1;
      if (started) begin
        for (int k = 0; k < 4; k++) exp_hex[7*k +: 7] = glyph[m_hex[4*k +: 4]];
        chk("rd_valid", {31'b0, bus.rd_valid}, {31'b0, m_rv});
        chk("read_data", {16'b0, bus.read_data}, {16'b0, m_rd});
        chk("led_out", {22'b0, led_out}, {22'b0, m_led});
        chk("hex_seg", {4'b0, hex_seg}, {4'b0, exp_hex});
`ifdef MMIO_IO_BRIDGE_IRQ_EN
        chk("irq", {31'b0, irq}, {31'b0, m_irq});
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic do_read(input logic [8:0] addr, output logic [15:0] data, output logic v);
    bus.mem_cmd  = 2'b01;
    bus.mem_addr = addr;
    step();
    data = bus.read_data;
    v    = bus.rd_valid;
    bus.mem_cmd = 2'b00;
  endtask

  task automatic do_write(input logic [8:0] addr, input logic [15:0] data);
    bus.mem_cmd    = 2'b10;
    bus.mem_addr   = addr;
    bus.write_data = data;
    step();
    bus.mem_cmd = 2'b00;
  endtask

  initial begin : stim
    logic [15:0] d;
    logic        v;
    logic [8:0]  rd_addrs [3];
    int          b;
    reset_n        = 1'b0;
    sw_in          = '0;
    bus.mem_cmd    = 2'b00;
    bus.mem_addr   = '0;
    bus.write_data = '0;
    step();
    step();
    reset_n = 1'b1;

    // reset state
    chk("rst_led", {22'b0, led_out}, 32'h0);
    chk("rst_hex", {4'b0, hex_seg}, 32'h8102040);
    chk("rst_rd_valid", {31'b0, bus.rd_valid}, 32'h0);
    chk("rst_read_data", {16'b0, bus.read_data}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      do_read(BASE + 9'(i), d, v);
      chk("rst_read_valid", {31'b0, v}, 32'h1);
      chk("rst_read_zero", {16'b0, d}, 32'h0);
    end

    // LED / HEX
    do_write(BASE + 9'd2, 16'hFFFF);
    chk("led_all", {22'b0, led_out}, 32'h3FF);
    do_read(BASE + 9'd2, d, v);
    chk("led_readback", {16'b0, d}, 32'h03FF);
    do_write(BASE + 9'd3, 16'h12AF);
    chk("hex_digit0_F", {25'b0, hex_seg[6:0]}, 32'h0E);
    chk("hex_digit1_A", {25'b0, hex_seg[13:7]}, 32'h08);
    chk("hex_digit3_1", {25'b0, hex_seg[27:21]}, 32'h79);
    do_read(BASE + 9'd3, d, v);
    chk("hex_readback", {16'b0, d}, 32'h12AF);

    // debounce latency: visible in SW_DATA exactly 6 edges after the pin change
    sw_in[3] = 1'b1;
    repeat (5) step();
    do_read(BASE, d, v);
    chk("debounce_not_yet", {16'b0, d}, 32'h0);
    do_read(BASE, d, v);
    chk("debounce_set", {16'b0, d}, 32'h0008);

    // short glitch rejected
    sw_in[5] = 1'b1;
    repeat (3) step();
    sw_in[5] = 1'b0;
    repeat (8) step();
    do_read(BASE, d, v);
    chk("glitch_rejected", {16'b0, d}, 32'h0008);

    // edge capture and W1C
    do_write(BASE + 9'd1, 16'hFFFF);
    sw_in[0] = 1'b1;
    sw_in[9] = 1'b1;
    repeat (8) step();
    do_read(BASE + 9'd1, d, v);
    chk("edge_two", {16'b0, d}, 32'h0201);
    do_write(BASE + 9'd1, 16'h0001);
    do_read(BASE + 9'd1, d, v);
    chk("edge_w1c", {16'b0, d}, 32'h0200);
    sw_in[0] = 1'b0;
    repeat (8) step();
    do_read(BASE + 9'd1, d, v);
    chk("edge_no_fall", {16'b0, d}, 32'h0200);
    sw_in[0] = 1'b1;
    repeat (5) step();
    do_write(BASE + 9'd1, 16'h0001);   // lands on the edge where bit0 rises
    do_read(BASE + 9'd1, d, v);
    chk("edge_set_wins", {16'b0, d}, 32'h0201);

    // decode
    do_write(9'h14A, 16'h0000);
    do_write(BASE + 9'd5, 16'h0000);
    do_read(BASE + 9'd2, d, v);
    chk("decode_led_kept", {16'b0, d}, 32'h03FF);
    do_read(BASE + 9'd5, d, v);
    chk("unmapped_valid", {31'b0, v}, 32'h1);
    chk("unmapped_zero", {16'b0, d}, 32'h0);
    do_read(9'h000, d, v);
    chk("miss_no_valid", {31'b0, v}, 32'h0);

    // back-to-back reads
    rd_addrs[0] = BASE + 9'd2;
    rd_addrs[1] = BASE + 9'd3;
    rd_addrs[2] = BASE;
    bus.mem_cmd = 2'b01;
    for (int i = 0; i < 3; i++) begin
      bus.mem_addr = rd_addrs[i];
      step();
      chk("pipe_valid", {31'b0, bus.rd_valid}, 32'h1);
    end
    bus.mem_cmd = 2'b00;
    step();
    chk("pipe_done", {31'b0, bus.rd_valid}, 32'h0);

`ifdef MMIO_IO_BRIDGE_IRQ_EN
    do_write(BASE + 9'd4, 16'h0004);
    sw_in[2] = 1'b1;
    repeat (8) step();
    chk("irq_set", {31'b0, irq}, 32'h1);
    do_write(BASE + 9'd1, 16'h0004);
    step();
    chk("irq_cleared", {31'b0, irq}, 32'h0);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      bus.mem_cmd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) != 0) bus.mem_addr = BASE + 9'($urandom_range(0, 7));
      else bus.mem_addr = 9'($urandom_range(0, 511));
      bus.write_data = 16'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        b = int'($urandom_range(0, SW - 1));
        sw_in[b] = ~sw_in[b];
      end
      step();
    end
    reset_n     = 1'b1;
    bus.mem_cmd = 2'b00;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
